// File: rtl/key_conditioner.sv
// Key input conditioner: sync, debounce, press/release edges and auto-repeat per key.
// Latency: 2 clk sync + debounce window to key_level; edge/repeat pulses one clock later.
// Backpressure: none; free-running stream, every output is a level or a 1-clock pulse.
module key_conditioner #(
  parameter int w_key          = 8,
  parameter int tick_div       = 27000,
  parameter int debounce_ticks = 10,
  parameter int repeat_delay   = 400,
  parameter int repeat_period  = 100
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [w_key-1:0] key_raw,
  output logic [w_key-1:0] key_level,
  output logic [w_key-1:0] key_press,
  output logic [w_key-1:0] key_release,
  output logic [w_key-1:0] key_repeat
);

  // Widths are sized so that each counter is cleared at its terminal count
  // and can never wrap.
  localparam int tick_w  = (tick_div > 2) ? $clog2(tick_div) : 1;
  localparam int db_w    = $clog2(debounce_ticks + 1);
  localparam int rpt_max = (repeat_delay > repeat_period) ? repeat_delay : repeat_period;
  localparam int rpt_w   = $clog2(rpt_max + 1);

  localparam logic [tick_w-1:0] tick_last  = tick_w'(tick_div - 1);
  localparam logic [tick_w-1:0] tick_one   = tick_w'(1);
  localparam logic [db_w-1:0]   db_last    = db_w'(debounce_ticks - 1);
  localparam logic [db_w-1:0]   db_one     = db_w'(1);
  localparam logic [rpt_w-1:0]  delay_last = rpt_w'(repeat_delay - 1);
  localparam logic [rpt_w-1:0]  per_last   = rpt_w'(repeat_period - 1);
  localparam logic [rpt_w-1:0]  rpt_one    = rpt_w'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_t;

  // Two-flop synchroniser; sync2_q is the usable "sync" value.
  logic [w_key-1:0] sync1_q;
  logic [w_key-1:0] sync2_q;

  // Shared millisecond prescaler.
  logic [tick_w-1:0] tick_cnt_q;
  logic [tick_w-1:0] tick_cnt_d;
  logic              tick;

  // Debounce state.
  logic [db_w-1:0]  db_cnt_q [w_key];
  logic [db_w-1:0]  db_cnt_d [w_key];
  logic [w_key-1:0] level_q;
  logic [w_key-1:0] level_d;

  // Edge detection.
  logic [w_key-1:0] level_dly_q;
  logic [w_key-1:0] rise;
  logic [w_key-1:0] fall;
  logic [w_key-1:0] press_q;
  logic [w_key-1:0] release_q;

  // Auto-repeat state.
  rpt_state_t       rpt_state_q [w_key];
  logic [rpt_w-1:0] rpt_cnt_q   [w_key];
  logic [w_key-1:0] repeat_q;

  // Bring the asynchronous key lines into the clock domain.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
    end
  end

  // Prescaler next state: wrap to zero on the tick cycle.
  always_comb begin
    tick_cnt_d = tick ? '0 : (tick_cnt_q + tick_one);
  end

  assign tick = (tick_cnt_q == tick_last);

  // Prescaler register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // Debounce next state: a differing input must survive debounce_ticks ticks
  // uninterrupted; any cycle where it agrees again restarts the count.
  always_comb begin
    level_d = level_q;
    for (int k = 0; k < w_key; k++) begin
      db_cnt_d[k] = db_cnt_q[k];
      if (sync2_q[k] == level_q[k]) begin
        db_cnt_d[k] = '0;
      end else if (tick) begin
        if (db_cnt_q[k] == db_last) begin
          level_d[k]  = ~level_q[k];
          db_cnt_d[k] = '0;
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + db_one;
        end
      end
    end
  end

  // Debounce registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= '0;
      for (int k = 0; k < w_key; k++) begin
        db_cnt_q[k] <= '0;
      end
    end else begin
      level_q <= level_d;
      for (int k = 0; k < w_key; k++) begin
        db_cnt_q[k] <= db_cnt_d[k];
      end
    end
  end

  // Compare the clean level against its one-clock-old copy.
  always_comb begin
    rise = level_q & ~level_dly_q;
    fall = ~level_q & level_dly_q;
  end

  // Register the edge pulses so they appear the cycle after key_level moves.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      level_dly_q <= '0;
      press_q     <= '0;
      release_q   <= '0;
    end else begin
      level_dly_q <= level_q;
      press_q     <= rise;
      release_q   <= fall;
    end
  end

  // Per-key repeat FSM. It looks at the next key_level so that a release
  // landing on the same tick as a repeat expiry suppresses the repeat, and no
  // repeat is emitted from the cycle key_level falls onwards. The rise is the
  // same term that feeds press_q, so the first repeat lines up with key_press.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      repeat_q <= '0;
      for (int k = 0; k < w_key; k++) begin
        rpt_state_q[k] <= ST_IDLE;
        rpt_cnt_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < w_key; k++) begin
        repeat_q[k] <= 1'b0;
        if (!level_d[k]) begin
          rpt_state_q[k] <= ST_IDLE;
          rpt_cnt_q[k]   <= '0;
        end else begin
          case (rpt_state_q[k])
            ST_IDLE: begin
              if (rise[k]) begin
                repeat_q[k]    <= 1'b1;
                rpt_cnt_q[k]   <= '0;
                rpt_state_q[k] <= ST_DELAY;
              end
            end
            ST_DELAY: begin
              if (tick) begin
                if (rpt_cnt_q[k] == delay_last) begin
                  repeat_q[k]    <= 1'b1;
                  rpt_cnt_q[k]   <= '0;
                  rpt_state_q[k] <= ST_REPEAT;
                end else begin
                  rpt_cnt_q[k] <= rpt_cnt_q[k] + rpt_one;
                end
              end
            end
            ST_REPEAT: begin
              if (tick) begin
                if (rpt_cnt_q[k] == per_last) begin
                  repeat_q[k]  <= 1'b1;
                  rpt_cnt_q[k] <= '0;
                end else begin
                  rpt_cnt_q[k] <= rpt_cnt_q[k] + rpt_one;
                end
              end
            end
            default: begin
              rpt_state_q[k] <= ST_IDLE;
              rpt_cnt_q[k]   <= '0;
            end
          endcase
        end
      end
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_repeat  = repeat_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner with a 4-clock tick, 3-tick debounce, 5/2-tick repeat.
// Expected output events (cycle since reset release plus all four output buses)
// are queued by the stimulus; a negedge monitor consumes them in order.
module tb_key_conditioner;

  typedef struct {
    int         cyc;
    logic [7:0] lvl;
    logic [7:0] prs;
    logic [7:0] rel;
    logic [7:0] rpt;
  } ev_t;

  logic       clock;
  logic       reset_n;
  logic [7:0] key_raw;
  logic [7:0] key_level;
  logic [7:0] key_press;
  logic [7:0] key_release;
  logic [7:0] key_repeat;

  int   cyc;
  int   checks;
  int   fails;
  int   rd_idx;
  logic probe;
  logic end_req;
  logic end_done;
  logic [7:0] prev_level;
  ev_t  exp_q[$];
  ev_t  cur;

  key_conditioner #(
    .w_key(8),
    .tick_div(4),
    .debounce_ticks(3),
    .repeat_delay(5),
    .repeat_period(2)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .key_raw(key_raw),
    .key_level(key_level),
    .key_press(key_press),
    .key_release(key_release),
    .key_repeat(key_repeat)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Cycle index: after the k-th rising edge following reset release, cyc == k.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic ev(input int c, input logic [7:0] l, input logic [7:0] p,
                    input logic [7:0] r, input logic [7:0] t);
    ev_t e;
    e.cyc = c; e.lvl = l; e.prs = p; e.rel = r; e.rpt = t;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    int guard;
    guard = 0;
    do begin
      @(negedge clock);
      guard++;
    end while (cyc != n && guard < 2000);
    if (cyc != n) begin
      $display("FAIL wait_cyc: cyc=%0d, required %0d (timeout)", cyc, n);
      $fatal(1, "cycle wait expired");
    end
  endtask

  // Monitor: zero outputs under reset; otherwise every output event must match
  // the next queued expectation exactly, including the cycle it happens on.
  initial begin
    checks = 0; fails = 0; rd_idx = 0; end_done = 1'b0; prev_level = '0;
    forever begin
      @(negedge clock or posedge probe);
      if (!reset_n) begin
        checks++;
        if ({key_level, key_press, key_release, key_repeat} != 32'h0) begin
          fails++;
          $display("FAIL reset_zero: got lvl=%h prs=%h rel=%h rpt=%h, required all 00",
                   key_level, key_press, key_release, key_repeat);
        end
        prev_level = '0;
      end else begin
        if ((key_press | key_release | key_repeat) != 8'h0 || key_level != prev_level) begin
          checks++;
          if (rd_idx >= exp_q.size()) begin
            fails++;
            $display("FAIL unexpected_event: cyc=%0d lvl=%h prs=%h rel=%h rpt=%h, required no event",
                     cyc, key_level, key_press, key_release, key_repeat);
          end else begin
            cur = exp_q[rd_idx];
            if (cur.cyc != cyc || cur.lvl != key_level || cur.prs != key_press ||
                cur.rel != key_release || cur.rpt != key_repeat) begin
              fails++;
              $display("FAIL event%0d: got cyc=%0d lvl=%h prs=%h rel=%h rpt=%h, required cyc=%0d lvl=%h prs=%h rel=%h rpt=%h",
                       rd_idx, cyc, key_level, key_press, key_release, key_repeat,
                       cur.cyc, cur.lvl, cur.prs, cur.rel, cur.rpt);
            end
            rd_idx++;
          end
        end
        prev_level = key_level;
        if (end_req && !end_done) begin
          checks++;
          if (rd_idx != exp_q.size()) begin
            fails++;
            $display("FAIL missing_events: consumed %0d, required %0d", rd_idx, exp_q.size());
          end
          end_done = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1;
    key_raw = 8'hFF;
    probe   = 1'b0;
    end_req = 1'b0;

    // Reset with all keys held: outputs must stay zero.
    #1 reset_n = 1'b0;
    #1 probe = 1'b1;
    #1 probe = 1'b0;

    // All keys held through reset, then released at cycle 33.
    ev(12, 8'hFF, 8'h00, 8'h00, 8'h00);
    ev(13, 8'hFF, 8'hFF, 8'h00, 8'hFF);
    ev(32, 8'hFF, 8'h00, 8'h00, 8'hFF);
    ev(40, 8'hFF, 8'h00, 8'h00, 8'hFF);
    ev(44, 8'h00, 8'h00, 8'h00, 8'h00);
    ev(45, 8'h00, 8'h00, 8'hFF, 8'h00);
    // Clean press and early release of key 7.
    ev(64, 8'h80, 8'h00, 8'h00, 8'h00);
    ev(65, 8'h80, 8'h80, 8'h00, 8'h80);
    ev(80, 8'h00, 8'h00, 8'h00, 8'h00);
    ev(81, 8'h00, 8'h00, 8'h80, 8'h00);
    // Key 0 bounce produces nothing. Key 5 auto-repeat; release lands on the
    // tick where the next repeat would have fired (260) and wins.
    ev(192, 8'h20, 8'h00, 8'h00, 8'h00);
    ev(193, 8'h20, 8'h20, 8'h00, 8'h20);
    ev(212, 8'h20, 8'h00, 8'h00, 8'h20);
    ev(220, 8'h20, 8'h00, 8'h00, 8'h20);
    ev(228, 8'h20, 8'h00, 8'h00, 8'h20);
    ev(236, 8'h20, 8'h00, 8'h00, 8'h20);
    ev(244, 8'h20, 8'h00, 8'h00, 8'h20);
    ev(252, 8'h20, 8'h00, 8'h00, 8'h20);
    ev(260, 8'h00, 8'h00, 8'h00, 8'h00);
    ev(261, 8'h00, 8'h00, 8'h20, 8'h00);
    // Key 2 reaches REPEAT before the mid-run reset.
    ev(284, 8'h04, 8'h00, 8'h00, 8'h00);
    ev(285, 8'h04, 8'h04, 8'h00, 8'h04);
    ev(304, 8'h04, 8'h00, 8'h00, 8'h04);
    ev(312, 8'h04, 8'h00, 8'h00, 8'h04);

    repeat (4) @(negedge clock);
    #1 reset_n = 1'b1;

    wait_cyc(33);  key_raw = 8'h00;
    wait_cyc(50);  key_raw = 8'h80;
    wait_cyc(66);  key_raw = 8'h00;

    for (int i = 0; i < 16; i++) begin
      wait_cyc(90 + 5 * i);
      key_raw[0] = (i % 2 == 0);
    end

    wait_cyc(180); key_raw = 8'h20;
    wait_cyc(248); key_raw = 8'h00;
    wait_cyc(270); key_raw = 8'h04;

    // Asynchronous reset mid-REPEAT, off the clock edge and off the tick.
    wait_cyc(315);
    #2 reset_n = 1'b0;
    #1 probe = 1'b1;
    #1 probe = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);

    // Key 2 still held: fresh debounce, press, and repeat from the delay phase.
    ev(12, 8'h04, 8'h00, 8'h00, 8'h00);
    ev(13, 8'h04, 8'h04, 8'h00, 8'h04);
    ev(32, 8'h04, 8'h00, 8'h00, 8'h04);
    ev(40, 8'h04, 8'h00, 8'h00, 8'h04);
    ev(44, 8'h00, 8'h00, 8'h00, 8'h00);
    ev(45, 8'h00, 8'h00, 8'h04, 8'h00);
    #1 reset_n = 1'b1;

    wait_cyc(33);  key_raw = 8'h00;
    wait_cyc(60);
    end_req = 1'b1;
    @(negedge clock);
    @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
